// File: rtl/jk_counter_driver.sv
// rtl/jk_counter_driver.sv - JK excitation driver for a negedge-clocked modulo-MOD flop bank.
// Keeps a shadow count, issues per-bit J/K each posedge and latches a sticky feedback error.
module jk_counter_driver #(
  parameter int WIDTH      = 4,
  parameter int MOD        = 10,
  parameter bit USE_TOGGLE = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic [WIDTH-1:0] Q_fb,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Count,
  output logic             Tc,
  output logic             Err
);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_FAULT} state_t;

  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MOD - 1);

  state_t           state_q;
  logic [WIDTH-1:0] count_q, j_q, k_q;
  logic             tc_q, err_q;

  logic [WIDTH-1:0] t_d, j_d, k_d;
  logic             wrap_d;

  always_comb begin
    t_d    = count_q;
    wrap_d = 1'b0;
    if (Load) begin
      t_d = ({1'b0, LoadVal} < MOD_W) ? LoadVal : '0;
    end else if (En && Up) begin
      wrap_d = (count_q == TOP);
      t_d    = wrap_d ? '0 : count_q + 1'b1;
    end else if (En) begin
      wrap_d = (count_q == '0);
      t_d    = wrap_d ? TOP : count_q - 1'b1;
    end
    // Toggle mode drives every changing bit with 11; otherwise a plain set/clear.
    if (USE_TOGGLE) begin
      j_d = count_q ^ t_d;
      k_d = count_q ^ t_d;
    end else begin
      j_d = t_d & ~count_q;
      k_d = count_q & ~t_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_INIT;
      count_q <= '0;
      j_q     <= '0;
      k_q     <= '0;
      tc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          state_q <= S_RUN;
          count_q <= '0;
          j_q     <= '0;
          k_q     <= '0;
          tc_q    <= 1'b0;
        end
        S_RUN: begin
          if (Q_fb != count_q) begin
            state_q <= S_FAULT;
            err_q   <= 1'b1;
            j_q     <= '0;
            k_q     <= '0;
            tc_q    <= 1'b0;
          end else begin
            count_q <= t_d;
            j_q     <= j_d;
            k_q     <= k_d;
            tc_q    <= wrap_d;
          end
        end
        default: begin
          state_q <= S_FAULT;
          err_q   <= 1'b1;
          j_q     <= '0;
          k_q     <= '0;
          tc_q    <= 1'b0;
        end
      endcase
    end
  end

  assign J     = j_q;
  assign K     = k_q;
  assign Count = count_q;
  assign Tc    = tc_q;
  assign Err   = err_q;

endmodule
